// File: rtl/hamdec_pkg.sv
// rtl/hamdec_pkg.sv - shared state encoding, flag codes and codeword bit positions for the SEC-DED engine
package hamdec_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_LO,
      S_RD_HI,
      S_CAP,
      S_DEC,
      S_WR_LO,
      S_WR_HI,
      S_DONE
   } state_t;

   localparam logic [1:0] FLAG_CLEAN  = 2'b00;
   localparam logic [1:0] FLAG_SINGLE = 2'b01;
   localparam logic [1:0] FLAG_DOUBLE = 2'b10;

   // Check-bit positions inside the 16-bit codeword; bit 0 is overall parity
   localparam int P16 = 0;
   localparam int P1  = 1;
   localparam int P2  = 2;
   localparam int P4  = 4;
   localparam int P8  = 8;

endpackage

// File: rtl/hamming_secded_dec.sv
// rtl/hamming_secded_dec.sv - combinational SEC-DED decode of one 16-bit codeword into flags and 11 data bits
module hamming_secded_dec
   import hamdec_pkg::*;
(
   input  logic [15:0] i_cw,
   output logic [1:0]  o_flags,
   output logic [10:0] o_data
);

   logic [3:0]  w_syn;
   logic        w_par;
   logic [15:0] w_fix;

   always_comb begin
      w_syn   = '0;
      w_par   = ^i_cw;
      w_fix   = i_cw;
      o_flags = FLAG_CLEAN;
      for (int k = 1; k < 16; k++) begin
         if (i_cw[k]) begin
            w_syn = w_syn ^ 4'(k);
         end
      end
      if (w_syn == 4'd0) begin
         // Zero syndrome with odd parity means only the overall parity bit flipped
         if (w_par) begin
            o_flags = FLAG_SINGLE;
         end
      end else if (w_par) begin
         w_fix[w_syn] = ~w_fix[w_syn];
         o_flags      = FLAG_SINGLE;
      end else begin
         o_flags = FLAG_DOUBLE;
      end
      o_data = {w_fix[15:P8+1], w_fix[P8-1:P4+1], w_fix[P4-1]};
   end

endmodule

// File: rtl/hamming_secded_engine.sv
// rtl/hamming_secded_engine.sv - batch SEC-DED decoder sharing a byte-wide memory port
// Optional error counters are enabled with HAMDEC_STATS_EN.
module hamming_secded_engine
   import hamdec_pkg::*;
#(
   parameter int SRC_BASE  = 64,
   parameter int DST_BASE  = 94,
   parameter int NUM_WORDS = 15,
   parameter int AW        = 8
) (
   input  logic          CLK,
   input  logic          reset,
   input  logic          start,
   output logic          halt,
   output logic [AW-1:0] mem_addr,
   output logic          mem_rd_en,
   input  logic [7:0]    mem_rdata,
   output logic          mem_wr_en,
`ifdef HAMDEC_STATS_EN
   output logic [7:0]    mem_wdata,
   output logic [6:0]    single_cnt,
   output logic [6:0]    double_cnt
`else
   output logic [7:0]    mem_wdata
`endif
);

   state_t      r_state;
   state_t      w_next;
   logic [6:0]  r_idx;
   logic [15:0] r_cw;
   logic [15:0] r_result;
   logic        r_halt;

   logic [1:0]    w_flags;
   logic [10:0]   w_data;
   logic          w_last;
   logic [AW-1:0] w_src_addr;
   logic [AW-1:0] w_dst_addr;

   hamming_secded_dec u_dec (
      .i_cw    (r_cw),
      .o_flags (w_flags),
      .o_data  (w_data)
   );

   assign w_last     = (r_idx == 7'(NUM_WORDS - 1));
   assign w_src_addr = AW'(SRC_BASE) + AW'({r_idx, 1'b0});
   assign w_dst_addr = AW'(DST_BASE) + AW'({r_idx, 1'b0});
   assign halt       = r_halt;

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (start) w_next = S_RD_LO;
         S_RD_LO: w_next = S_RD_HI;
         S_RD_HI: w_next = S_CAP;
         S_CAP:   w_next = S_DEC;
         S_DEC:   w_next = S_WR_LO;
         S_WR_LO: w_next = S_WR_HI;
         S_WR_HI: w_next = w_last ? S_DONE : S_RD_LO;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Read data arrives one cycle after the strobe, so each byte lands one state later
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         r_idx    <= '0;
         r_cw     <= '0;
         r_result <= '0;
         r_halt   <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_halt <= 1'b0;
                  r_idx  <= '0;
               end
            end
            S_RD_HI: r_cw[7:0]  <= mem_rdata;
            S_CAP:   r_cw[15:8] <= mem_rdata;
            S_DEC:   r_result   <= {w_flags, 3'b000, w_data};
            S_WR_HI: if (!w_last) r_idx <= r_idx + 7'd1;
            S_DONE:  r_halt <= 1'b1;
            default: ;
         endcase
      end
   end

   always_comb begin
      mem_addr  = '0;
      mem_rd_en = 1'b0;
      mem_wr_en = 1'b0;
      mem_wdata = '0;
      unique case (r_state)
         S_RD_LO: begin
            mem_rd_en = 1'b1;
            mem_addr  = w_src_addr;
         end
         S_RD_HI: begin
            mem_rd_en = 1'b1;
            mem_addr  = w_src_addr + AW'(1);
         end
         S_WR_LO: begin
            mem_wr_en = 1'b1;
            mem_addr  = w_dst_addr;
            mem_wdata = r_result[7:0];
         end
         S_WR_HI: begin
            mem_wr_en = 1'b1;
            mem_addr  = w_dst_addr + AW'(1);
            mem_wdata = r_result[15:8];
         end
         default: ;
      endcase
   end

`ifdef HAMDEC_STATS_EN
   logic [6:0] r_single_cnt;
   logic [6:0] r_double_cnt;

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         r_single_cnt <= '0;
         r_double_cnt <= '0;
      end else if (r_state == S_IDLE && start) begin
         r_single_cnt <= '0;
         r_double_cnt <= '0;
      end else if (r_state == S_DEC) begin
         if (w_flags == FLAG_SINGLE) r_single_cnt <= r_single_cnt + 7'd1;
         if (w_flags == FLAG_DOUBLE) r_double_cnt <= r_double_cnt + 7'd1;
      end
   end

   assign single_cnt = r_single_cnt;
   assign double_cnt = r_double_cnt;
`endif

endmodule
